// File: rtl/io_uart_tx_pkg.sv
// Shared types and constants for the processor-port UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit between data and stop.
package io_uart_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam logic [7:0] IO_ADDR  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO feeding the UART serializer.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module io_byte_fifo
    import io_uart_tx_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/io_uart_tx.sv
// Buffered 8-bit UART transmitter on processor output port 0xFF.
// Define UART_TX_PARITY_EN to send an even-parity bit before stop.
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    tx_state_t   state_nxt;
    logic [15:0] baud;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        bit_done;
    logic        tx_nxt;
    logic        busy_nxt;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
`endif

    assign full     = fifo_full;
    assign bit_done = (baud == BAUD_LAST);

    io_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_done)
                    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && bit_cnt == 3'd7)
`ifdef UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done)
                    state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Back-to-back frames: chain straight into the next start bit.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state != ST_IDLE) || !fifo_empty;
        unique case (state)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_nxt = par_q;
`endif
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
            baud     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            tx   <= tx_nxt;
            busy <= busy_nxt;
            if (state == ST_IDLE || bit_done)
                baud <= '0;
            else
                baud <= baud + 16'd1;
            if (pop)
                shreg <= fifo_dout;
            else if (state == ST_DATA && bit_done)
                shreg <= {1'b0, shreg[7:1]};
            if (state == ST_DATA && bit_done)
                bit_cnt <= bit_cnt + 3'd1;
            if (wr_en && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            par_q <= 1'b0;
        else if (pop)
            par_q <= even_parity(fifo_dout);
    end
`endif

endmodule
